decoder_scan: RTL and testbench

DECODER_SCAN -- requirements
Module: decoder_scan

---
 rtl/decoder_pkg.sv | 16 +
 rtl/onehot_dec.sv | 14 +
 rtl/decoder_scan.sv | 134 +++++++++++++
 tb/tb_decoder_scan.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared encodings for the decoder_scan block: operating modes and FSM states.
package decoder_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_PULSE  = 2'b01,
        MODE_SCAN   = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

endpackage : decoder_pkg

// File: rtl/onehot_dec.sv
// Purely combinational index to one-hot conversion.
module onehot_dec #(
    parameter int SEL_W = 2
) (
    input  logic [SEL_W-1:0]    idx_i,
    output logic [2**SEL_W-1:0] onehot_o
);

    always_comb begin
        onehot_o        = '0;
        onehot_o[idx_i] = 1'b1;
    end

endmodule : onehot_dec

// File: rtl/decoder_scan.sv
// Registered one-hot decoder with DIRECT, PULSE and SCAN modes; every output
// is taken straight from a flop.
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 load,
    input  logic [DWELL_W-1:0]   dwell,
    output logic [2**SEL_W-1:0]  y,
    output logic [SEL_W-1:0]     active_idx,
    output logic                 busy,
    output logic                 wrap
);

    localparam int N_OUT = 2**SEL_W;

    state_e               state_q, state_d;
    logic [SEL_W-1:0]     idx_q, idx_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic [N_OUT-1:0]     y_q, y_d;
    logic [SEL_W-1:0]     act_q, act_d;
    logic                 busy_q, busy_d;
    logic                 wrap_q, wrap_d;

    mode_e                mode_s;
    logic [SEL_W-1:0]     dec_idx;
    logic [N_OUT-1:0]     dec_y;
    logic                 y_on;

    assign mode_s = mode_e'(mode);

    onehot_dec #(
        .SEL_W (SEL_W)
    ) u_dec (
        .idx_i    (dec_idx),
        .onehot_o (dec_y)
    );

    // Next-state logic; dec_idx picks the index the decoder shows next cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        dec_idx = sel;
        y_on    = 1'b0;
        wrap_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    case (mode_s)
                        MODE_SCAN: begin
                            if (load) begin
                                state_d = ST_SCAN;
                                idx_d   = sel;
                                dwell_d = dwell;
                                cnt_d   = '0;
                                y_on    = 1'b1;
                            end
                        end
                        MODE_PULSE: y_on = load;
                        default:    y_on = 1'b1;
                    endcase
                end
            end
            ST_SCAN: begin
                // Leaving SCAN always costs one dark cycle before the new mode.
                if (!en || mode_s != MODE_SCAN) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (load) begin
                    idx_d   = sel;
                    dwell_d = dwell;
                    cnt_d   = '0;
                    y_on    = 1'b1;
                end else if (cnt_q == dwell_q) begin
                    dec_idx = idx_q + SEL_W'(1);
                    idx_d   = dec_idx;
                    cnt_d   = '0;
                    y_on    = 1'b1;
                    wrap_d  = (idx_q == {SEL_W{1'b1}});
                end else begin
                    dec_idx = idx_q;
                    cnt_d   = cnt_q + DWELL_W'(1);
                    y_on    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        y_d    = y_on ? dec_y : '0;
        act_d  = y_on ? dec_idx : '0;
        busy_d = (state_d == ST_SCAN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            dwell_q <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            act_q   <= '0;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            act_q   <= act_d;
            busy_q  <= busy_d;
            wrap_q  <= wrap_d;
        end
    end

    assign y          = y_q;
    assign active_idx = act_q;
    assign busy       = busy_q;
    assign wrap       = wrap_q;

endmodule : decoder_scan

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan: directed vector table, reset sequence, and random
// stimulus against a time-based behavioural model.
module tb_decoder_scan;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [1:0] sel = 2'b00;
    logic       load = 1'b0;
    logic [3:0] dwell = 4'd0;
    logic [3:0] y;
    logic [1:0] active_idx;
    logic       busy;
    logic       wrap;

    int n_checks = 0;
    int n_fail   = 0;

    decoder_scan #(.SEL_W(2), .DWELL_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mode       (mode),
        .sel        (sel),
        .load       (load),
        .dwell      (dwell),
        .y          (y),
        .active_idx (active_idx),
        .busy       (busy),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       en;
        logic [1:0] mode;
        logic       load;
        logic [1:0] sel;
        logic [3:0] dwell;
        logic [3:0] y;
        logic [1:0] act;
        logic       busy;
        logic       wrap;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic e, input logic [1:0] m, input logic l,
                       input logic [1:0] s, input logic [3:0] d,
                       input logic [3:0] ey, input logic [1:0] ea,
                       input logic eb, input logic ew);
        vec_t v;
        v.en = e; v.mode = m; v.load = l; v.sel = s; v.dwell = d;
        v.y = ey; v.act = ea; v.busy = eb; v.wrap = ew;
        tbl.push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [1:0] m, input logic l,
                         input logic [1:0] s, input logic [3:0] d);
        en = e; mode = m; load = l; sel = s; dwell = d;
    endtask

    // Reference model: SCAN position derived from cycles elapsed since the load.
    bit m_scan;
    int m_s, m_d, m_k;
    int e_idx;
    bit e_wrap;

    task automatic model(input logic e, input logic [1:0] m, input logic l,
                         input logic [1:0] s, input logic [3:0] d);
        e_idx  = -1;
        e_wrap = 0;
        if (m_scan) begin
            if (!e || m != 2'b10) begin
                m_scan = 0;
            end else if (l) begin
                m_s = s; m_d = d; m_k = 0; e_idx = s;
            end else begin
                m_k++;
                e_idx  = (m_s + m_k / (m_d + 1)) % 4;
                e_wrap = (m_k % (m_d + 1) == 0) && (e_idx == 0);
            end
        end else if (e) begin
            if (m == 2'b10) begin
                if (l) begin
                    m_scan = 1; m_s = s; m_d = d; m_k = 0; e_idx = s;
                end
            end else if (m == 2'b01) begin
                if (l) e_idx = s;
            end else begin
                e_idx = s;
            end
        end
    endtask

    initial begin
        // DIRECT
        add(1, 2'd0, 0, 2'd0, 4'd0, 4'b0001, 2'd0, 0, 0);
        add(1, 2'd0, 0, 2'd1, 4'd0, 4'b0010, 2'd1, 0, 0);
        add(1, 2'd0, 1, 2'd2, 4'd0, 4'b0100, 2'd2, 0, 0);
        add(1, 2'd0, 0, 2'd3, 4'd0, 4'b1000, 2'd3, 0, 0);
        add(0, 2'd0, 0, 2'd3, 4'd0, 4'b0000, 2'd0, 0, 0);
        // PULSE
        add(1, 2'd1, 1, 2'd2, 4'd0, 4'b0100, 2'd2, 0, 0);
        add(1, 2'd1, 0, 2'd2, 4'd0, 4'b0000, 2'd0, 0, 0);
        add(1, 2'd1, 1, 2'd1, 4'd0, 4'b0010, 2'd1, 0, 0);
        add(1, 2'd1, 1, 2'd3, 4'd0, 4'b1000, 2'd3, 0, 0);
        add(1, 2'd1, 0, 2'd3, 4'd0, 4'b0000, 2'd0, 0, 0);
        // SCAN sel=3 dwell=1
        add(1, 2'd2, 1, 2'd3, 4'd1, 4'b1000, 2'd3, 1, 0);
        add(1, 2'd2, 0, 2'd0, 4'd0, 4'b1000, 2'd3, 1, 0);
        add(1, 2'd2, 0, 2'd0, 4'd0, 4'b0001, 2'd0, 1, 1);
        add(1, 2'd2, 0, 2'd0, 4'd0, 4'b0001, 2'd0, 1, 0);
        add(1, 2'd2, 0, 2'd0, 4'd0, 4'b0010, 2'd1, 1, 0);
        add(1, 2'd2, 0, 2'd0, 4'd0, 4'b0010, 2'd1, 1, 0);
        add(1, 2'd2, 0, 2'd0, 4'd0, 4'b0100, 2'd2, 1, 0);
        // restart mid-dwell with sel=0 dwell=0
        add(1, 2'd2, 1, 2'd0, 4'd0, 4'b0001, 2'd0, 1, 0);
        add(1, 2'd2, 0, 2'd2, 4'd5, 4'b0010, 2'd1, 1, 0);
        add(1, 2'd2, 0, 2'd2, 4'd5, 4'b0100, 2'd2, 1, 0);
        add(1, 2'd2, 0, 2'd2, 4'd5, 4'b1000, 2'd3, 1, 0);
        add(1, 2'd2, 0, 2'd2, 4'd5, 4'b0001, 2'd0, 1, 1);
        // SCAN -> DIRECT sel=1
        add(1, 2'd0, 0, 2'd1, 4'd0, 4'b0000, 2'd0, 0, 0);
        add(1, 2'd0, 0, 2'd1, 4'd0, 4'b0010, 2'd1, 0, 0);
        // en drop during SCAN
        add(1, 2'd2, 1, 2'd2, 4'd2, 4'b0100, 2'd2, 1, 0);
        add(0, 2'd2, 0, 2'd2, 4'd2, 4'b0000, 2'd0, 0, 0);
        add(0, 2'd2, 0, 2'd2, 4'd2, 4'b0000, 2'd0, 0, 0);
        // restart 3 -> 0 must not wrap
        add(1, 2'd2, 1, 2'd3, 4'd0, 4'b1000, 2'd3, 1, 0);
        add(1, 2'd2, 1, 2'd0, 4'd0, 4'b0001, 2'd0, 1, 0);
        add(1, 2'd2, 0, 2'd0, 4'd0, 4'b0010, 2'd1, 1, 0);
        // reserved mode leaves SCAN, then acts as DIRECT
        add(1, 2'd3, 0, 2'd2, 4'd0, 4'b0000, 2'd0, 0, 0);
        add(1, 2'd3, 0, 2'd2, 4'd0, 4'b0100, 2'd2, 0, 0);

        #2;
        check("reset_y", y, 4'b0000);
        check("reset_busy", busy, 1'b0);
        check("reset_wrap", wrap, 1'b0);
        check("reset_act", active_idx, 2'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();

        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].mode, tbl[i].load, tbl[i].sel, tbl[i].dwell);
            step();
            check($sformatf("row%0d_y", i), y, tbl[i].y);
            check($sformatf("row%0d_act", i), active_idx, tbl[i].act);
            check($sformatf("row%0d_busy", i), busy, tbl[i].busy);
            check($sformatf("row%0d_wrap", i), wrap, tbl[i].wrap);
        end

        // Asynchronous reset mid-SCAN, observed between clock edges.
        drive(1, 2'd2, 1, 2'd2, 4'd3);
        step();
        drive(1, 2'd2, 0, 2'd2, 4'd3);
        check("pre_rst_y", y, 4'b0100);
        check("pre_rst_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_y", y, 4'b0000);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_act", active_idx, 2'd0);
        step();
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("post_rst_idle_y%0d", c), y, 4'b0000);
            check($sformatf("post_rst_idle_busy%0d", c), busy, 1'b0);
        end
        drive(1, 2'd2, 1, 2'd1, 4'd0);
        step();
        check("post_rst_scan_y", y, 4'b0010);
        check("post_rst_scan_busy", busy, 1'b1);

        // Randomized run against the model, starting from a fresh reset.
        drive(0, 2'd0, 0, 2'd0, 4'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        m_scan = 0; m_s = 0; m_d = 0; m_k = 0;
        for (int c = 0; c < 3000; c++) begin
            logic       re, rl;
            logic [1:0] rm, rs;
            logic [3:0] rd;
            re = ($urandom_range(0, 15) != 0);
            rm = ($urandom_range(0, 3) != 0) ? 2'd2 : 2'($urandom_range(0, 3));
            rl = ($urandom_range(0, 9) < 2);
            rs = 2'($urandom_range(0, 3));
            rd = 4'($urandom_range(0, 3));
            drive(re, rm, rl, rs, rd);
            model(re, rm, rl, rs, rd);
            step();
            check($sformatf("rnd%0d_y", c), y, (e_idx >= 0) ? (4'b0001 << e_idx) : 4'b0000);
            check($sformatf("rnd%0d_act", c), active_idx, (e_idx >= 0) ? 2'(e_idx) : 2'd0);
            check($sformatf("rnd%0d_busy", c), busy, m_scan);
            check($sformatf("rnd%0d_wrap", c), wrap, e_wrap);
            check($sformatf("rnd%0d_onehot", c), ($countones(y) <= 1), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_decoder_scan
